align_exponents: RTL

Parametrised, two-stage pipelined exponent-compare and mantissa-alignment unit for the floating-point adder datapath. Each operand pair is accepted on a valid/ready handshake. The unit subtracts the exponents and picks the larger operand, with a mantissa tie-break on equal exponents. It then right-shifts the smaller mantissa by the exponent difference into a guard/round/sticky-extended field. Results feed the significand add/subtract and normalisation stages.

---
 rtl/align_exponents_if.sv | 36 +++
 rtl/align_exponents.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/align_exponents_if.sv
// Operand/result bundle for the exponent-compare and mantissa-alignment stage.
// The slave modport is the datapath side; the master modport is the producer/consumer side.
interface align_exponents_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic             sign1;
  logic             sign2;
  logic [EXP_W-1:0] exp1;
  logic [EXP_W-1:0] exp2;
  logic [MAN_W-1:0] man1;
  logic [MAN_W-1:0] man2;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_r;
  logic [EXP_W-1:0] diff;
  logic             swapped;
  logic             sign_big;
  logic             sign_small;
  logic [MAN_W-1:0] man_big;
  logic [MAN_W+2:0] man_small;

  modport slave (
    input  in_valid, sign1, sign2, exp1, exp2, man1, man2, out_ready,
    output in_ready, out_valid, exp_r, diff, swapped, sign_big, sign_small,
           man_big, man_small
  );

  modport master (
    output in_valid, sign1, sign2, exp1, exp2, man1, man2, out_ready,
    input  in_ready, out_valid, exp_r, diff, swapped, sign_big, sign_small,
           man_big, man_small
  );
endinterface

// File: rtl/align_exponents.sv
// Two-stage exponent compare and small-mantissa alignment for the FP adder.
// Stage 1 orders the operands; stage 2 shifts the small significand into a G/R/S-extended field.
module align_exponents #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input logic               clk,
  input logic               rst,
  align_exponents_if.slave  bus
);
  localparam int AW = MAN_W + 3;

  function automatic logic sticky_of(input logic [AW-1:0] ext, input logic [EXP_W-1:0] sh);
    logic [AW-1:0] mask;
    mask = ~({AW{1'b1}} << sh);
    return |(ext & mask);
  endfunction

  logic             adv1_s;
  logic             adv2_s;
  logic [EXP_W:0]   sub_s;
  logic             swap_s;
  logic [EXP_W-1:0] diff_s;
  logic [EXP_W-1:0] exp_big_s;
  logic [MAN_W-1:0] man_big_s;
  logic [MAN_W-1:0] man_small_s;
  logic             sign_big_s;
  logic             sign_small_s;
  logic [AW-1:0]    ext_s;
  logic [AW-1:0]    aligned_s;

  logic             s1_valid_r;
  logic [EXP_W-1:0] s1_exp_r;
  logic [EXP_W-1:0] s1_diff_r;
  logic             s1_swapped_r;
  logic             s1_sign_big_r;
  logic             s1_sign_small_r;
  logic [MAN_W-1:0] s1_man_big_r;
  logic [MAN_W-1:0] s1_man_small_r;

  logic             s2_valid_r;
  logic [EXP_W-1:0] s2_exp_r;
  logic [EXP_W-1:0] s2_diff_r;
  logic             s2_swapped_r;
  logic             s2_sign_big_r;
  logic             s2_sign_small_r;
  logic [MAN_W-1:0] s2_man_big_r;
  logic [AW-1:0]    s2_man_small_r;

  // A stage moves when its successor has room; in_ready follows out_ready without a bubble.
  assign adv2_s       = !s2_valid_r || bus.out_ready;
  assign adv1_s       = !s1_valid_r || adv2_s;
  assign bus.in_ready = adv1_s;

  // Operand ordering: borrow of the widened subtraction flags exp1 < exp2.
  always_comb begin
    sub_s  = {1'b0, bus.exp1} - {1'b0, bus.exp2};
    swap_s = sub_s[EXP_W] ||
             ((sub_s == {(EXP_W+1){1'b0}}) && (bus.man1 < bus.man2));
    if (swap_s) begin
      diff_s       = bus.exp2 - bus.exp1;
      exp_big_s    = bus.exp2;
      man_big_s    = bus.man2;
      man_small_s  = bus.man1;
      sign_big_s   = bus.sign2;
      sign_small_s = bus.sign1;
    end else begin
      diff_s       = sub_s[EXP_W-1:0];
      exp_big_s    = bus.exp1;
      man_big_s    = bus.man1;
      man_small_s  = bus.man2;
      sign_big_s   = bus.sign1;
      sign_small_s = bus.sign2;
    end
  end

  // Alignment shift; beyond the field width only the sticky of the whole mantissa survives.
  always_comb begin
    ext_s = {s1_man_small_r, 3'b000};
    if (32'(s1_diff_r) < AW) begin
      aligned_s = (ext_s >> s1_diff_r) | {{(AW-1){1'b0}}, sticky_of(ext_s, s1_diff_r)};
    end else begin
      aligned_s = {{(AW-1){1'b0}}, |s1_man_small_r};
    end
  end

  // Stage 1 register: compare results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r      <= 1'b0;
      s1_exp_r        <= {EXP_W{1'b0}};
      s1_diff_r       <= {EXP_W{1'b0}};
      s1_swapped_r    <= 1'b0;
      s1_sign_big_r   <= 1'b0;
      s1_sign_small_r <= 1'b0;
      s1_man_big_r    <= {MAN_W{1'b0}};
      s1_man_small_r  <= {MAN_W{1'b0}};
    end else if (adv1_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_exp_r        <= exp_big_s;
        s1_diff_r       <= diff_s;
        s1_swapped_r    <= swap_s;
        s1_sign_big_r   <= sign_big_s;
        s1_sign_small_r <= sign_small_s;
        s1_man_big_r    <= man_big_s;
        s1_man_small_r  <= man_small_s;
      end
    end
  end

  // Stage 2 register: aligned result, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r      <= 1'b0;
      s2_exp_r        <= {EXP_W{1'b0}};
      s2_diff_r       <= {EXP_W{1'b0}};
      s2_swapped_r    <= 1'b0;
      s2_sign_big_r   <= 1'b0;
      s2_sign_small_r <= 1'b0;
      s2_man_big_r    <= {MAN_W{1'b0}};
      s2_man_small_r  <= {AW{1'b0}};
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_exp_r        <= s1_exp_r;
        s2_diff_r       <= s1_diff_r;
        s2_swapped_r    <= s1_swapped_r;
        s2_sign_big_r   <= s1_sign_big_r;
        s2_sign_small_r <= s1_sign_small_r;
        s2_man_big_r    <= s1_man_big_r;
        s2_man_small_r  <= aligned_s;
      end
    end
  end

  assign bus.out_valid  = s2_valid_r;
  assign bus.exp_r      = s2_exp_r;
  assign bus.diff       = s2_diff_r;
  assign bus.swapped    = s2_swapped_r;
  assign bus.sign_big   = s2_sign_big_r;
  assign bus.sign_small = s2_sign_small_r;
  assign bus.man_big    = s2_man_big_r;
  assign bus.man_small  = s2_man_small_r;
endmodule
